// File: rtl/aes_wb_pkg.sv
// aes_wb_pkg: register map, CTRL/STATUS bit positions and FSM state encoding
// shared by the AES Wishbone bridge and its sequencer.
package aes_wb_pkg;

  // Word addresses (byte address bits [7:2]).
  localparam logic [5:0] ADR_CTRL     = 6'h00;
  localparam logic [5:0] ADR_STATUS   = 6'h01;
  localparam logic [5:0] ADR_TEXT_IN  = 6'h04;
  localparam logic [5:0] ADR_TEXT_OUT = 6'h08;
  localparam logic [5:0] ADR_KEY      = 6'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_KLD    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_TIMEOUT   = 2;
  localparam int ST_ERR       = 3;
  localparam int ST_KEY_VALID = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KLOAD = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  function automatic bit key_w_legal(input int w);
    return (w == 128) || (w == 192) || (w == 256);
  endfunction

endpackage

// File: rtl/aes_wb_fsm.sv
// aes_wb_fsm: IDLE/KLOAD/LOAD/RUN sequencer for the AES core, generating the
// key/text load pulses, the RUN watchdog and the status flag set strobes.
module aes_wb_fsm
  import aes_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  input  logic kld_req,
  input  logic key_valid,
  input  logic core_done,
  output logic busy,
  output logic core_kld,
  output logic core_ld,
  output logic set_done,
  output logic set_timeout,
  output logic set_err,
  output logic set_key_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  state_e           state_r, state_s;
  logic             pend_start_r, pend_start_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             kld_r, ld_r;

  // State, pending-start and watchdog registers; load pulses decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pend_start_r <= 1'b0;
      cnt_r        <= '0;
      kld_r        <= 1'b0;
      ld_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_start_r <= pend_start_s;
      cnt_r        <= cnt_s;
      kld_r        <= (state_s == S_KLOAD);
      ld_r         <= (state_s == S_LOAD);
    end
  end

  // Next-state logic and one-cycle flag set strobes.
  always_comb begin
    state_s       = state_r;
    pend_start_s  = pend_start_r;
    cnt_s         = cnt_r;
    set_done      = 1'b0;
    set_timeout   = 1'b0;
    set_err       = 1'b0;
    set_key_valid = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (kld_req) begin
          state_s      = S_KLOAD;
          pend_start_s = start_req;
        end else if (start_req) begin
          if (key_valid) begin
            state_s = S_LOAD;
          end else begin
            set_err = 1'b1;
          end
        end else begin
          pend_start_s = 1'b0;
        end
      end
      S_KLOAD: begin
        set_key_valid = 1'b1;
        pend_start_s  = 1'b0;
        state_s       = pend_start_r ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        cnt_s   = '0;
        state_s = S_RUN;
      end
      S_RUN: begin
        if (core_done) begin
          set_done = 1'b1;
          state_s  = S_IDLE;
        end else if (cnt_r + CNT_W'(1) == CNT_MAX) begin
          // Watchdog expires after exactly TIMEOUT_CYC cycles spent in RUN.
          set_timeout = 1'b1;
          state_s     = S_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_r != S_IDLE);
  assign core_kld = kld_r;
  assign core_ld  = ld_r;

endmodule

// File: rtl/aes_wb_bridge.sv
// aes_wb_bridge: Wishbone slave register file driving one AES core.
// Define AES_WB_IRQ_EN to add the irq_o level interrupt and CTRL.IRQ_EN bit.
module aes_wb_bridge
  import aes_wb_pkg::*;
#(
  parameter int KEY_W       = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [7:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             core_kld_o,
  output logic             core_ld_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [127:0]     core_text_o,
  input  logic [127:0]     core_text_i,
  input  logic             core_done_i
`ifdef AES_WB_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  localparam int KEY_WORDS = KEY_W / 32;

  if (!key_w_legal(KEY_W)) begin : g_key_w_check
    $error("aes_wb_bridge: KEY_W must be 128, 192 or 256");
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic        ack_r;
  logic [31:0] dat_r;
  logic [31:0] text_in_r  [4];
  logic [31:0] text_out_r [4];
  logic [31:0] key_r      [KEY_WORDS];
  logic        done_r, timeout_r, err_r, key_valid_r;

  logic        req_s, wr_s, busy_s;
  logic [5:0]  word_adr_s;
  logic        ctrl_wr_s, text_in_hit_s, text_out_hit_s, key_hit_s;
  logic        start_req_s, kld_req_s, busy_err_s;
  logic        fsm_done_s, fsm_timeout_s, fsm_err_s, fsm_key_valid_s;
  logic [4:0]  w1c_s;
  logic        done_s, timeout_s, err_s, key_valid_s;
  logic        irq_en_s;
  logic [31:0] rd_data_s;
  logic        unused_adr_s;

  assign unused_adr_s = ^wb_adr_i[1:0];
  assign req_s        = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s         = req_s & wb_we_i;
  assign word_adr_s   = wb_adr_i[7:2];

  // Address decode and command/error qualification for the current request.
  always_comb begin
    text_in_hit_s  = (word_adr_s[5:2] == ADR_TEXT_IN[5:2]);
    text_out_hit_s = (word_adr_s[5:2] == ADR_TEXT_OUT[5:2]);
    key_hit_s      = (word_adr_s >= ADR_KEY) && (word_adr_s < ADR_KEY + 6'(KEY_WORDS));
    ctrl_wr_s      = wr_s && (word_adr_s == ADR_CTRL) && wb_sel_i[0];
    start_req_s    = ctrl_wr_s && wb_dat_i[CTRL_START] && !busy_s;
    kld_req_s      = ctrl_wr_s && wb_dat_i[CTRL_KLD] && !busy_s;
    busy_err_s     = busy_s && ((ctrl_wr_s && (wb_dat_i[CTRL_START] || wb_dat_i[CTRL_KLD]))
                                || (wr_s && (text_in_hit_s || key_hit_s)));
  end

  aes_wb_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk           (wb_clk_i),
    .rst           (wb_rst_i),
    .start_req     (start_req_s),
    .kld_req       (kld_req_s),
    .key_valid     (key_valid_r),
    .core_done     (core_done_i),
    .busy          (busy_s),
    .core_kld      (core_kld_o),
    .core_ld       (core_ld_o),
    .set_done      (fsm_done_s),
    .set_timeout   (fsm_timeout_s),
    .set_err       (fsm_err_s),
    .set_key_valid (fsm_key_valid_s)
  );

  // Sticky status flags: a hardware set in the same cycle as W1C wins.
  always_comb begin
    w1c_s     = (wr_s && (word_adr_s == ADR_STATUS) && wb_sel_i[0]) ? wb_dat_i[4:0] : 5'b0;
    done_s    = fsm_done_s | (done_r & ~w1c_s[ST_DONE]);
    timeout_s = fsm_timeout_s | (timeout_r & ~w1c_s[ST_TIMEOUT]);
    err_s     = fsm_err_s | busy_err_s | (err_r & ~w1c_s[ST_ERR]);
    if (fsm_key_valid_s) begin
      key_valid_s = 1'b1;
    end else if (wr_s && key_hit_s && !busy_s) begin
      key_valid_s = 1'b0;
    end else begin
      key_valid_s = key_valid_r;
    end
  end

  // Flag registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      err_r       <= 1'b0;
      key_valid_r <= 1'b0;
    end else begin
      done_r      <= done_s;
      timeout_r   <= timeout_s;
      err_r       <= err_s;
      key_valid_r <= key_valid_s;
    end
  end

  // Data registers: byte-enabled TEXT_IN/KEY writes in IDLE, TEXT_OUT capture on done.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) begin
        text_in_r[i]  <= 32'h0;
        text_out_r[i] <= 32'h0;
      end
      for (int k = 0; k < KEY_WORDS; k++) begin
        key_r[k] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_s && !busy_s && (word_adr_s == ADR_TEXT_IN + 6'(i))) begin
          text_in_r[i] <= merge_bytes(text_in_r[i], wb_dat_i, wb_sel_i);
        end
        if (fsm_done_s) begin
          text_out_r[i] <= core_text_i[127-32*i -: 32];
        end
      end
      for (int k = 0; k < KEY_WORDS; k++) begin
        if (wr_s && !busy_s && (word_adr_s == ADR_KEY + 6'(k))) begin
          key_r[k] <= merge_bytes(key_r[k], wb_dat_i, wb_sel_i);
        end
      end
    end
  end

  // Word 0 of each block sits in the most significant bits.
  always_comb begin
    core_text_o = 128'h0;
    core_key_o  = '0;
    for (int i = 0; i < 4; i++) begin
      core_text_o[127-32*i -: 32] = text_in_r[i];
    end
    for (int k = 0; k < KEY_WORDS; k++) begin
      core_key_o[KEY_W-1-32*k -: 32] = key_r[k];
    end
  end

  // Read mux; KEY and unmapped locations read as zero.
  always_comb begin
    rd_data_s = 32'h0;
    if (word_adr_s == ADR_CTRL) begin
      rd_data_s[CTRL_IRQ_EN] = irq_en_s;
    end else if (word_adr_s == ADR_STATUS) begin
      rd_data_s[ST_BUSY]      = busy_s;
      rd_data_s[ST_DONE]      = done_r;
      rd_data_s[ST_TIMEOUT]   = timeout_r;
      rd_data_s[ST_ERR]       = err_r;
      rd_data_s[ST_KEY_VALID] = key_valid_r;
    end else if (text_in_hit_s || text_out_hit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (word_adr_s[1:0] == 2'(i)) begin
          rd_data_s = text_in_hit_s ? text_in_r[i] : text_out_r[i];
        end
      end
    end else begin
      rd_data_s = 32'h0;
    end
  end

  // Single-cycle acknowledge with registered read data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0;
    end else begin
      ack_r <= req_s;
      dat_r <= (req_s && !wb_we_i) ? rd_data_s : 32'h0;
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;

`ifdef AES_WB_IRQ_EN
  logic irq_en_r, irq_r, irq_en_n_s;

  assign irq_en_n_s = ctrl_wr_s ? wb_dat_i[CTRL_IRQ_EN] : irq_en_r;

  // Interrupt level follows the next flag values so it rises with DONE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irq_en_r <= irq_en_n_s;
      irq_r    <= irq_en_n_s & (done_s | timeout_s | err_s);
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq_o    = irq_r;
`else
  assign irq_en_s = 1'b0;
`endif

endmodule

// File: tb/tb_aes_wb_bridge.sv
// tb_aes_wb_bridge: directed plus randomized self-checking bench for aes_wb_bridge
// with a register-level reference model and a scripted AES core.
module tb_aes_wb_bridge;

  localparam int TIMEOUT_CYC = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   adr = 8'h0;
  logic [31:0]  wdat = 32'h0;
  logic [3:0]   sel = 4'h0;
  logic         we = 1'b0;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic [31:0]  rdat;
  logic         ack;
  logic         kld, ld;
  logic [127:0] key, text_o;
  logic [127:0] text_i = 128'h0;
  logic         done_i = 1'b0;
`ifdef AES_WB_IRQ_EN
  logic         irq;
`endif

  int total = 0;
  int bad   = 0;

  logic kld1, ld1, kld2, ld2;

  logic [31:0] m_text_in  [4];
  logic [31:0] m_text_out [4];
  logic [31:0] m_key      [4];
  bit          m_key_valid;

  aes_wb_bridge #(.KEY_W(128), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_i    (adr),
    .wb_dat_i    (wdat),
    .wb_sel_i    (sel),
    .wb_we_i     (we),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_dat_o    (rdat),
    .wb_ack_o    (ack),
    .core_kld_o  (kld),
    .core_ld_o   (ld),
    .core_key_o  (key),
    .core_text_o (text_o),
    .core_text_i (text_i),
    .core_done_i (done_i)
`ifdef AES_WB_IRQ_EN
    ,
    .irq_o       (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] masked(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  function automatic logic [127:0] model_key();
    return {m_key[0], m_key[1], m_key[2], m_key[3]};
  endfunction

  function automatic logic [127:0] model_text_in();
    return {m_text_in[0], m_text_in[1], m_text_in[2], m_text_in[3]};
  endfunction

  function automatic logic [31:0] status_word(input bit busy, input bit dn, input bit to, input bit er);
    return {27'h0, m_key_valid, er, to, dn, busy};
  endfunction

  // Called at a negedge; request is sampled at the next posedge, ack seen one cycle later.
  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; wdat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kld1 = kld; ld1 = ld;
    check("wr_ack", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    kld2 = kld; ld2 = ld;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    adr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d = rdat;
    check("rd_ack", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rd_ack_single", ack, 1'b0);
  endtask

  task automatic write_key(input int k, input logic [31:0] d);
    wb_write(8'(8'h40 + 4 * k), d, 4'hF);
    m_key[k] = d;
    m_key_valid = 1'b0;
  endtask

  task automatic write_text(input int i, input logic [31:0] d, input logic [3:0] s);
    wb_write(8'(8'h10 + 4 * i), d, s);
    m_text_in[i] = masked(m_text_in[i], d, s);
  endtask

  task automatic check_text_out(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      wb_read(8'(8'h20 + 4 * i), d);
      check(tag, d, m_text_out[i]);
    end
  endtask

  // Full operation: CTRL write, core answers 'delay' cycles after the load, DONE cleared.
  task automatic do_run(input bit with_kld, input logic [127:0] result, input int delay);
    logic [31:0] d;
    wb_write(8'h00, with_kld ? 32'h0000_0003 : 32'h0000_0001, 4'hF);
    if (with_kld) begin
      check("kld_then_ld", {kld1, ld1, kld2, ld2}, 4'b1001);
      check("core_key", key, model_key());
      m_key_valid = 1'b1;
    end else begin
      check("ld_pulse", {kld1, ld1}, 2'b01);
    end
    check("core_text", text_o, model_text_in());
    repeat (delay) @(negedge clk);
    text_i = result; done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    for (int i = 0; i < 4; i++) m_text_out[i] = result[127-32*i -: 32];
    wb_read(8'h04, d);
    check("status_done", d, status_word(1'b0, 1'b1, 1'b0, 1'b0));
    check_text_out("text_out");
    wb_write(8'h04, 32'h0000_0002, 4'hF);
  endtask

  initial begin
    logic [31:0]  d;
    logic [127:0] r;
    logic [31:0]  ctrl_extra;
    int           ld_seen;

    for (int i = 0; i < 4; i++) begin
      m_text_in[i] = 32'h0; m_text_out[i] = 32'h0; m_key[i] = 32'h0;
    end
    m_key_valid = 1'b0;
`ifdef AES_WB_IRQ_EN
    ctrl_extra = 32'h0000_0004;
`else
    ctrl_extra = 32'h0000_0000;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outs", {ack, kld, ld, rdat}, 35'h0);
    check("rst_key", key, 128'h0);
    check("rst_text", text_o, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    wb_read(8'h04, d);
    check("rst_status", d, 32'h0);

    // START without a key: no load pulse, ERR set, then W1C clears it.
    ld_seen = 0;
    wb_write(8'h00, 32'h0000_0001, 4'hF);
    for (int c = 0; c < 4; c++) begin
      if (ld) ld_seen++;
      @(negedge clk);
    end
    check("no_ld_pulses", ld_seen + int'(ld1) + int'(ld2), 0);
    wb_read(8'h04, d);
    check("status_err", d, status_word(1'b0, 1'b0, 1'b0, 1'b1));
    wb_write(8'h04, 32'h0000_0008, 4'hF);
    wb_read(8'h04, d);
    check("status_err_clr", d, 32'h0);

    // Known-answer style run with KLD|START.
    for (int k = 0; k < 4; k++) write_key(k, 32'h00010203 + 32'h04040404 * k);
    for (int i = 0; i < 4; i++) write_text(i, 32'h00112233 + 32'h44444444 * i, 4'hF);
    do_run(1'b1, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 9);

    // Byte enables and unmapped/KEY reads.
    write_text(1, 32'h0, 4'hF);
    write_text(1, 32'hAABBCCDD, 4'b0010);
    wb_read(8'h14, d);
    check("sel_merge", d, m_text_in[1]);
    check("sel_merge_const", d, 32'h0000_CC00);
    wb_read(8'h40, d);
    check("key_reads_zero", d, 32'h0);
    wb_write(8'h30, 32'hFFFF_FFFF, 4'hF);
    wb_read(8'h30, d);
    check("unmapped_zero", d, 32'h0);

    // Write during BUSY is dropped and flags ERR.
    wb_write(8'h00, 32'h0000_0001, 4'hF);
    wb_write(8'h10, 32'hDEAD_BEEF, 4'hF);
    repeat (3) @(negedge clk);
    r = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    text_i = r; done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    for (int i = 0; i < 4; i++) m_text_out[i] = r[127-32*i -: 32];
    wb_read(8'h10, d);
    check("busy_write_dropped", d, m_text_in[0]);
    wb_read(8'h04, d);
    check("busy_write_err", d, status_word(1'b0, 1'b1, 1'b0, 1'b1));
    wb_write(8'h04, 32'h0000_000A, 4'hF);

    // Watchdog boundary: sampled on the last RUN edge, then one edge later.
    for (int t = 0; t < 2; t++) begin
      wb_write(8'h00, 32'h0000_0001, 4'hF);
      repeat (TIMEOUT_CYC - 1 + t) @(negedge clk);
      wb_read(8'h04, d);
      if (t == 0) check("timeout_last_run", d, status_word(1'b1, 1'b0, 1'b0, 1'b0));
      else        check("timeout_first_idle", d, status_word(1'b0, 1'b0, 1'b1, 1'b0));
      repeat (4) @(negedge clk);
      wb_read(8'h04, d);
      check("timeout_set", d, status_word(1'b0, 1'b0, 1'b1, 1'b0));
      check_text_out("timeout_text_kept");
      wb_write(8'h04, 32'h0000_0004, 4'hF);
    end

    // W1C DONE in the same cycle as the core's done strobe.
    wb_read(8'h04, d);
    check("pre_w1c_status", d, status_word(1'b0, 1'b0, 1'b0, 1'b0));
    wb_write(8'h00, 32'h0000_0001 | ctrl_extra, 4'hF);
    repeat (3) @(negedge clk);
    r = {$urandom, $urandom, $urandom, $urandom};
    fork
      wb_write(8'h04, 32'h0000_0002, 4'hF);
      begin
        text_i = r; done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
      end
    join
    for (int i = 0; i < 4; i++) m_text_out[i] = r[127-32*i -: 32];
`ifdef AES_WB_IRQ_EN
    check("irq_set_wins", irq, 1'b1);
`endif
    wb_read(8'h04, d);
    check("set_wins_w1c", d, status_word(1'b0, 1'b1, 1'b0, 1'b0));
    check_text_out("w1c_race_text");
    wb_write(8'h04, 32'h0000_0002, 4'hF);
`ifdef AES_WB_IRQ_EN
    check("irq_cleared", irq, 1'b0);
`endif

    // Reset in the middle of RUN; the late done must be ignored.
    wb_write(8'h00, 32'h0000_0001, 4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrun_rst_outs", {ack, kld, ld, rdat}, 35'h0);
    check("midrun_rst_key", key, 128'h0);
    check("midrun_rst_text", text_o, 128'h0);
`ifdef AES_WB_IRQ_EN
    check("midrun_rst_irq", irq, 1'b0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_text_in[i] = 32'h0; m_text_out[i] = 32'h0; m_key[i] = 32'h0;
    end
    m_key_valid = 1'b0;
    @(negedge clk);
    text_i = {4{32'hA5A5_5A5A}}; done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    wb_read(8'h04, d);
    check("late_done_ignored", d, 32'h0);
    check_text_out("late_done_text");

    // Randomized operations against the model.
    for (int it = 0; it < 6; it++) begin
      bit new_key;
      int w;
      logic [3:0] s;
      new_key = (it == 0) || ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) begin
        s = 4'($urandom_range(1, 15));
        write_text(i, $urandom, s);
      end
      w = $urandom_range(0, 3);
      wb_read(8'(8'h10 + 4 * w), d);
      check("rand_text_in", d, m_text_in[w]);
      if (new_key) begin
        for (int k = 0; k < 4; k++) write_key(k, $urandom);
        wb_read(8'h04, d);
        check("key_write_clears_kv", d, status_word(1'b0, 1'b0, 1'b0, 1'b0));
      end
      r = {$urandom, $urandom, $urandom, $urandom};
      do_run(new_key, r, $urandom_range(1, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
